// File: rtl/fir_tdm_pkg.sv
`default_nettype none
// ============================================================================
// fir_tdm_pkg : shared types and arithmetic helpers for the TDM FIR filter
// Rev 1.0
// ============================================================================
package fir_tdm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Round half up, arithmetic shift, then clamp to a signed data_w range.
    function automatic logic signed [63:0] sat_round_shift(input logic signed [63:0] acc,
                                                           input logic [4:0]         sh,
                                                           input int                 data_w);
        logic signed [63:0] rnd;
        logic signed [63:0] shifted;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rnd     = (sh == 5'd0) ? 64'sd0 : (64'sd1 <<< (sh - 5'd1));
        shifted = (acc + rnd) >>> sh;
        hi      = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (data_w - 1));
        if (shifted > hi) begin
            return hi;
        end
        if (shifted < lo) begin
            return lo;
        end
        return shifted;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_delay_store.sv
`default_nettype none
// ============================================================================
// fir_delay_store : per-channel circular sample history, read as (ch, k-back)
// Rev 1.0
// ============================================================================
module fir_delay_store #(
    parameter int DATA_W   = 16,
    parameter int TAPS     = 30,
    parameter int CHANNELS = 2,
    parameter int CH_W     = 1,
    parameter int PTR_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [CH_W-1:0]          wr_chan_i,
    input  logic signed [DATA_W-1:0] wr_data_i,
    input  logic [CH_W-1:0]          rd_chan_i,
    input  logic [PTR_W-1:0]         rd_k_i,
    output logic signed [DATA_W-1:0] rd_data_o
);

    localparam logic [PTR_W:0]   TAPS_X = (PTR_W + 1)'(TAPS);
    localparam logic [PTR_W:0]   ONE_X  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(TAPS - 1);

    logic signed [DATA_W-1:0] mem_q  [CHANNELS][TAPS];
    logic [PTR_W-1:0]         wptr_q [CHANNELS];
    logic [PTR_W:0]           w_idx_raw;
    logic [PTR_W-1:0]         w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                wptr_q[c] <= '0;
                for (int t = 0; t < TAPS; t++) begin
                    mem_q[c][t] <= '0;
                end
            end
        end else if (wr_en_i) begin
            mem_q[wr_chan_i][wptr_q[wr_chan_i]] <= wr_data_i;
            wptr_q[wr_chan_i] <= (wptr_q[wr_chan_i] == LAST) ? '0 : wptr_q[wr_chan_i] + 1'b1;
        end
    end

    // Write pointer sits one past the newest sample; step back k more, modulo TAPS.
    always_comb begin
        w_idx_raw = {1'b0, wptr_q[rd_chan_i]} + (TAPS_X - {1'b0, rd_k_i}) - ONE_X;
        w_idx     = (w_idx_raw >= TAPS_X) ? PTR_W'(w_idx_raw - TAPS_X) : PTR_W'(w_idx_raw);
        rd_data_o = mem_q[rd_chan_i][w_idx];
    end

endmodule
`default_nettype wire

// File: rtl/fir_tdm_multich.sv
`default_nettype none
// ============================================================================
// fir_tdm_multich : time-multiplexed multi-channel serial FIR, one MAC/cycle
// Rev 1.0
// ============================================================================
module fir_tdm_multich
    import fir_tdm_pkg::*;
#(
    parameter int  DATA_W   = 16,
    parameter int  COEF_W   = 16,
    parameter int  TAPS     = 30,
    parameter int  CHANNELS = 2,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PTR_W    = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               right_shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_chan,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_wr_en,
    input  logic [PTR_W-1:0]         coef_wr_addr,
    input  logic signed [COEF_W-1:0] coef_wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH_W-1:0]          out_chan,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int               ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int               PROD_W = DATA_W + COEF_W;
    localparam logic [PTR_W-1:0] LAST_K = PTR_W'(TAPS - 1);

    state_t                   state_q, state_d;
    logic [PTR_W-1:0]         k_q, k_d;
    logic [CH_W-1:0]          ch_q, ch_d;
    logic [4:0]               shift_q, shift_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] out_data_q, out_data_d;
    logic signed [COEF_W-1:0] coef_q [TAPS];

    logic                     w_accept;
    logic                     w_coef_wr;
    logic signed [DATA_W-1:0] w_sample;
    logic signed [COEF_W-1:0] w_coef;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_acc_sum;

    // Out-of-range channels are still handshaken in IDLE, just never stored.
    assign w_accept  = (state_q == IDLE) && in_valid && (int'(in_chan) < CHANNELS);
    assign w_coef_wr = (state_q == IDLE) && coef_wr_en && (int'(coef_wr_addr) < TAPS);

    fir_delay_store #(
        .DATA_W   (DATA_W),
        .TAPS     (TAPS),
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W),
        .PTR_W    (PTR_W)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_accept),
        .wr_chan_i (in_chan),
        .wr_data_i (in_data),
        .rd_chan_i (ch_q),
        .rd_k_i    (k_q),
        .rd_data_o (w_sample)
    );

    assign w_coef    = coef_q[k_q];
    assign w_prod    = $signed({{COEF_W{w_sample[DATA_W-1]}}, w_sample})
                     * $signed({{DATA_W{w_coef[COEF_W-1]}}, w_coef});
    assign w_acc_sum = acc_q + $signed({{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod});

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < TAPS; t++) begin
                coef_q[t] <= '0;
            end
        end else if (w_coef_wr) begin
            coef_q[coef_wr_addr] <= coef_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            ch_q       <= '0;
            shift_q    <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            ch_q       <= ch_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        ch_d       = ch_q;
        shift_d    = shift_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    state_d = MAC;
                    ch_d    = in_chan;
                    shift_d = right_shift;
                    acc_d   = '0;
                    k_d     = '0;
                end
            end
            MAC: begin
                acc_d = w_acc_sum;
                k_d   = k_q + 1'b1;
                if (k_q == LAST_K) begin
                    state_d    = OUT;
                    k_d        = '0;
                    out_data_d = DATA_W'(sat_round_shift(
                                     $signed({{(64 - ACC_W){w_acc_sum[ACC_W-1]}}, w_acc_sum}),
                                     shift_q, DATA_W));
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_chan = ch_q;
    assign out_data = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tdm_multich.sv
`default_nettype none
// ============================================================================
// tb_fir_tdm_multich : vector tables, corner sequences and random vs model
// Rev 1.0
// ============================================================================
module tb_fir_tdm_multich;

    localparam int DATA_W   = 16;
    localparam int COEF_W   = 16;
    localparam int TAPS     = 30;
    localparam int CHANNELS = 2;
    localparam int CH_W     = 1;
    localparam int PTR_W    = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [4:0]               right_shift;
    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_chan;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_wr_en;
    logic [PTR_W-1:0]         coef_wr_addr;
    logic signed [COEF_W-1:0] coef_wr_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_chan;
    logic signed [DATA_W-1:0] out_data;

    always #5 clk = ~clk;

    fir_tdm_multich #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .TAPS     (TAPS),
        .CHANNELS (CHANNELS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .right_shift  (right_shift),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_chan      (in_chan),
        .in_data      (in_data),
        .coef_wr_en   (coef_wr_en),
        .coef_wr_addr (coef_wr_addr),
        .coef_wr_data (coef_wr_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_chan     (out_chan),
        .out_data     (out_data)
    );

    typedef struct {
        int     ch;
        longint data;
        int     sh;
        longint exp;
    } vec_t;

    int     total = 0;
    int     bad   = 0;
    vec_t   vecs[$];
    longint hist  [CHANNELS][TAPS];   // hist[c][k] = sample accepted k acceptances ago
    longint mcoef [TAPS];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < CHANNELS; c++)
            for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
        for (int k = 0; k < TAPS; k++) mcoef[k] = 0;
    endfunction

    function automatic void model_push(input int ch, input longint s);
        for (int k = TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = s;
    endfunction

    function automatic longint model_out(input int ch, input int sh);
        longint acc = 0;
        longint r;
        longint hi = (longint'(1) << (DATA_W - 1)) - 1;
        longint lo = -(longint'(1) << (DATA_W - 1));
        for (int k = 0; k < TAPS; k++) acc += hist[ch][k] * mcoef[k];
        if (sh > 0) acc += longint'(1) << (sh - 1);
        r = acc >>> sh;
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction

    function automatic void add_vec(input int ch, input longint d, input int sh, input longint e);
        vec_t v;
        v.ch = ch; v.data = d; v.sh = sh; v.exp = e;
        vecs.push_back(v);
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; coef_wr_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic write_coef(input int addr, input longint val);
        coef_wr_en   = 1'b1;
        coef_wr_addr = addr[PTR_W-1:0];
        coef_wr_data = val[COEF_W-1:0];
        @(negedge clk);
        coef_wr_en = 1'b0;
        if (addr < TAPS) mcoef[addr] = val;
    endtask

    task automatic send(input int ch, input longint data, input int sh,
                        input bit wr_same, input int wa, input longint wv, input int mid_wr,
                        output longint got, output int gch, output int lat);
        int n;
        in_valid    = 1'b1;
        in_chan     = ch[CH_W-1:0];
        in_data     = data[DATA_W-1:0];
        right_shift = sh[4:0];
        if (wr_same) begin
            coef_wr_en   = 1'b1;
            coef_wr_addr = wa[PTR_W-1:0];
            coef_wr_data = wv[COEF_W-1:0];
            if (wa < TAPS) mcoef[wa] = wv;
        end
        model_push(ch, data);
        @(negedge clk);
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            if (n == mid_wr) begin
                coef_wr_en   = 1'b1;
                coef_wr_addr = '0;
                coef_wr_data = 16'sd999;
            end
            @(negedge clk);
            coef_wr_en = 1'b0;
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", longint'(out_valid), 1);
        got = longint'($signed(out_data));
        gch = int'(out_chan);
        lat = n;
        @(negedge clk);
    endtask

    task automatic run_vecs(input string tag);
        longint got;
        int     gch;
        int     lat;
        foreach (vecs[i]) begin
            send(vecs[i].ch, vecs[i].data, vecs[i].sh, 1'b0, 0, 0, 0, got, gch, lat);
            chk($sformatf("%s_data[%0d]", tag, i), got, vecs[i].exp);
            chk($sformatf("%s_model[%0d]", tag, i), got, model_out(vecs[i].ch, vecs[i].sh));
            chk($sformatf("%s_chan[%0d]", tag, i), longint'(gch), longint'(vecs[i].ch));
            chk($sformatf("%s_latency[%0d]", tag, i), longint'(lat), TAPS + 1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint got, exp, hold_d;
        int     gch, lat, viol, n, ch, sh, wa;
        logic [CH_W-1:0] hold_c;

        rst = 1'b1; in_valid = 1'b0; in_chan = '0; in_data = '0; right_shift = '0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0; out_ready = 1'b1;
        do_reset();
        chk("rst_in_ready",  longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_chan",  longint'(out_chan), 0);
        chk("rst_out_data",  longint'($signed(out_data)), 0);

        // Impulse through a ramp of coefficients
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        vecs.delete();
        add_vec(0, 1, 0, 1);
        for (int i = 1; i < TAPS; i++) add_vec(0, 0, 0, i + 1);
        run_vecs("impulse");

        // Channel isolation
        do_reset();
        write_coef(0, 2);
        vecs.delete();
        add_vec(0, 100, 0, 200);
        add_vec(1, -100, 0, -200);
        for (int i = 0; i < 4; i++) add_vec(i % 2, 0, 0, 0);
        run_vecs("iso");

        // Saturation both ways
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 32767);
        vecs.delete();
        for (int i = 0; i < TAPS; i++) add_vec(0, 32767, 0, 32767);
        for (int i = 1; i <= TAPS; i++)
            add_vec(0, -32768, 0,
                    (-32768 * i + 32767 * (TAPS - i)) > 0 ? 32767 : -32768);
        run_vecs("sat");

        // Round half up
        do_reset();
        write_coef(0, 3);
        vecs.delete();
        add_vec(0, 1, 1, 2);
        add_vec(0, -1, 1, -1);
        add_vec(0, 5, 2, 4);
        add_vec(1, -2, 3, -1);
        run_vecs("round");

        // Backpressure: output held, junk input ignored
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        send(0, 3, 0, 1'b0, 0, 0, 0, got, gch, lat);
        chk("bp_pre", got, 3);
        out_ready = 1'b0;
        in_valid = 1'b1; in_chan = '0; in_data = 16'sd7; right_shift = '0;
        model_push(0, 7);
        @(negedge clk);
        in_data = 16'sd1000;
        viol = 0;
        n = 1;
        while (!out_valid && n < 100) begin
            if (in_ready) viol++;
            @(negedge clk);
            n++;
        end
        chk("bp_latency", longint'(n), TAPS + 1);
        chk("bp_data", longint'($signed(out_data)), model_out(0, 0));
        hold_d = longint'($signed(out_data));
        hold_c = out_chan;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!out_valid || longint'($signed(out_data)) != hold_d || out_chan != hold_c || in_ready)
                viol++;
        end
        chk("bp_hold_violations", longint'(viol), 0);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_after", longint'(in_ready), 1);
        chk("bp_out_valid_after", longint'(out_valid), 0);
        send(0, 0, 0, 1'b0, 0, 0, 0, got, gch, lat);
        chk("bp_next_model", got, model_out(0, 0));
        chk("bp_next_const", got, 23);

        // Coefficient writes: ignored mid-MAC, applied on acceptance cycle
        do_reset();
        write_coef(0, 5);
        send(0, 1, 0, 1'b0, 0, 0, 5, got, gch, lat);
        chk("cw_mid_mac", got, 5);
        send(0, 2, 0, 1'b0, 0, 0, 0, got, gch, lat);
        chk("cw_after", got, 10);
        send(0, 3, 0, 1'b1, 0, -4, 0, got, gch, lat);
        chk("cw_same_cycle", got, -12);

        // Reset at k=10
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        send(0, 5, 0, 1'b0, 0, 0, 0, got, gch, lat);
        send(1, 9, 0, 1'b0, 0, 0, 0, got, gch, lat);
        in_valid = 1'b1; in_chan = '0; in_data = 16'sd4;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < 11; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || !in_ready) viol++;
            @(negedge clk);
        end
        chk("rstmac_quiet_violations", longint'(viol), 0);
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        send(0, 1, 0, 1'b0, 0, 0, 0, got, gch, lat);
        chk("rstmac_ch0", got, 1);
        send(1, 1, 0, 1'b0, 0, 0, 0, got, gch, lat);
        chk("rstmac_ch1", got, 1);

        // Reset while holding a result
        out_ready = 1'b0;
        in_valid = 1'b1; in_chan = '0; in_data = 16'sd2;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstout_reached", longint'(out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstout_valid_drop", longint'(out_valid), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        model_clear();
        @(negedge clk);

        // Random traffic against the reference model
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, longint'($urandom_range(0, 4000)) - 2000);
        for (int i = 0; i < 40; i++) begin
            ch = int'($urandom_range(0, CHANNELS - 1));
            sh = int'($urandom_range(0, 31));
            wa = int'($urandom_range(0, TAPS - 1));
            send(ch, longint'($urandom_range(0, 65535)) - 32768, sh,
                 ($urandom_range(0, 3) == 0), wa, longint'($urandom_range(0, 4000)) - 2000, 0,
                 got, gch, lat);
            exp = model_out(ch, sh);
            chk($sformatf("rand_data[%0d]", i), got, exp);
            chk($sformatf("rand_chan[%0d]", i), longint'(gch), longint'(ch));
            chk($sformatf("rand_latency[%0d]", i), longint'(lat), TAPS + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_tdm_multich.md
Name: fir_tdm_multich

Overview:
- Time-multiplexed, multi-channel serial FIR filter with one MAC per cycle.
- Replaces the fixed single-channel 16-bit filter. Adds parameterised data/coefficient widths and a runtime-writable coefficient bank.
- Adds ready/valid handshakes on both sides, plus round-half-up scaling and saturation on the output.
- Sits between the sample-rate ADC/decimation path and downstream audio/DSP consumers.

Parameters:
- DATA_W, 16, sample and output width (signed)
- COEF_W, 16, coefficient width (signed)
- TAPS, 30, filter length (>=2)
- CHANNELS, 2, independent channels sharing one coefficient set (>=1)
- ACC_W, DATA_W+COEF_W+$clog2(TAPS), accumulator width (derived; not overridden)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- right_shift  in  5  output scale-down amount, sampled at sample acceptance
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_chan  in  max(1,$clog2(CHANNELS))  channel index of input sample
- in_data  in  DATA_W  signed input sample
- coef_wr_en  in  1  coefficient write strobe
- coef_wr_addr  in  $clog2(TAPS)  tap index
- coef_wr_data  in  COEF_W  signed coefficient value
- out_valid  out  1  filtered result valid
- out_ready  in  1  downstream accepts result
- out_chan  out  max(1,$clog2(CHANNELS))  channel of result
- out_data  out  DATA_W  signed filtered result

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset clears all delay-line entries, channel write pointers, coefficients (all 0), accumulator and state (IDLE).
- Output reset values: in_ready=1, out_valid=0, out_chan=0, out_data=0.
- States: IDLE, MAC, OUT.
- IDLE: in_ready=1. When in_valid:
  - write in_data into channel ch's circular delay line at wptr[ch], then advance wptr[ch] (wrap TAPS-1 -> 0);
  - latch ch and right_shift, clear acc, k=0, go to MAC.
- MAC: one tap per cycle for k=0..TAPS-1.
  - acc += sample(ch, newest-k) * coef[k], a full-precision signed product sign-extended to ACC_W.
  - sample(ch, newest-k) is the sample written k acceptances ago on that channel.
  - After k=TAPS-1, go to OUT with out_valid=1.
- OUT: out_data = sat_DATA_W((acc + (right_shift ? 1<<(right_shift-1) : 0)) >>> right_shift).
  - Saturation clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_valid, out_chan and out_data hold stable until out_ready; on out_valid&&out_ready go to IDLE.
- Latency: acceptance at cycle 0; out_valid first high at cycle TAPS+1. Throughput is one sample per TAPS+2 cycles with out_ready held high.
- in_ready=0 in MAC and OUT. in_valid there is ignored and not buffered.
- in_chan >= CHANNELS: the sample is handshaken (consumed) but dropped. No state change, no output.
- Coefficient writes take effect only in IDLE and are silently ignored in MAC/OUT.
- A write in the same IDLE cycle as a sample acceptance is applied, and that sample's MAC uses the new value.
- coef_wr_addr >= TAPS is ignored.
- Channels are fully independent. A sample on channel 1 never affects channel 0 history.
- rst mid-MAC or mid-OUT discards the computation: out_valid drops the next cycle and the delay lines are cleared.
- No output pulse is produced by reset.

Decomposition:
- Package fir_tdm_pkg holds:
  - the state enum (IDLE, MAC, OUT);
  - an acc_width function(DATA_W, COEF_W, TAPS);
  - a saturating rounding-shift function used for OUT.
- One sub-module, fir_delay_store: a CHANNELS x TAPS circular sample store with per-channel write pointers, a write port, and a combinational read port addressed by (ch, k). Its read port returns sample(ch, newest-k).
- Controller, MAC and output logic live in fir_tdm_multich.

Test Plan:
- Impulse, CHANNELS=2, TAPS=30:
  - Stimulus: coef[k]=k+1, right_shift=0; ch0 sample 1 followed by 29 zeros.
  - Required: 30 ch0 outputs 1,2,...,30. Each out_valid appears exactly 31 cycles after its acceptance.
- Channel isolation:
  - Stimulus: interleave ch0=100 and ch1=-100 impulses with coef[0]=2, others 0.
  - Required: ch0 outputs 200 and ch1 outputs -200, with zero cross-talk on later zero-input samples.
- Rounding/saturation:
  - Stimulus: all coef=32767, 30 samples of 32767, right_shift=0.
  - Required: out_data=32767 saturated. Repeat with -32768 samples -> -32768.
  - Stimulus: coef[0]=3, sample 1, right_shift=1.
  - Required: out_data=2 (1.5 rounds up).
- Backpressure:
  - Stimulus: hold out_ready=0 for 50 cycles after out_valid, and drive in_valid throughout.
  - Required: out_data/out_chan stable, in_ready=0, no sample lost or accepted until the output handshake, then in_ready=1 next cycle.
- Coefficient write during MAC:
  - Stimulus: write coef[0]=999 mid-MAC.
  - Required: ignored; coef[0] unchanged on the next impulse.
- Reset mid-MAC:
  - Stimulus: assert rst at k=10.
  - Required: out_valid stays 0, in_ready=1 after reset, and the next impulse on ch0 yields an output equal to coef[0] only (history cleared).
